ct_f_spsram_acc_ctrl: RTL and testbench



---
 rtl/ct_f_spsram_acc_ctrl.sv | 148 ++++++++++++++
 tb/tb_ct_f_spsram_acc_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_acc_ctrl.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_acc_ctrl
//
// Requester-side controller for a single-port SRAM macro. It turns a
// valid/ready request stream into SRAM cycles and returns read data on a
// valid/ready response stream. It can optionally zero-fill the array after
// reset.
//
// Handshake semantics (both streams): a beat transfers on a rising edge where
// vld && rdy are both high. A producer holds vld and its payload stable until
// the transfer. req_rdy never depends on req_vld, but it does depend on
// req_wr. rsp_rdata holds stable while rsp_vld && !rsp_rdy.
//
// Ports
//   CLK, RST              clock; synchronous active-high reset
//   req_vld/req_rdy       request handshake
//   req_wr                1 = write, 0 = read
//   req_addr              request address
//   req_wdata/req_wmask   write data and active-high per-bit write enables
//   rsp_vld/rsp_rdy       read response handshake
//   rsp_rdata             read data
//   init_done             array is filled and requests can be taken
//   sram_A/CEN/GWEN/WEN/D SRAM inputs (CEN, GWEN, WEN are active-low)
//   sram_Q                SRAM read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module ct_f_spsram_acc_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 54,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_A,
    output logic                  sram_CEN,
    output logic                  sram_GWEN,
    output logic [DATA_WIDTH-1:0] sram_WEN,
    output logic [DATA_WIDTH-1:0] sram_D,
    input  logic [DATA_WIDTH-1:0] sram_Q
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] init_cnt_nxt;
    logic                  rd_inflight;
    logic                  xfer;
    logic                  rd_xfer;

    // -----------------------------------------------------------------------
    // State register, read pipeline and response register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt    <= '0;
            rd_inflight <= 1'b0;
            rsp_vld     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_nxt;
            init_cnt    <= init_cnt_nxt;
            rd_inflight <= rd_xfer;
            // A capture wins over a same-edge handshake so the new read
            // result is never dropped.
            if (rd_inflight) begin
                rsp_vld   <= 1'b1;
                rsp_rdata <= sram_Q;
            end else if (rsp_vld && rsp_rdy) begin
                rsp_vld <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state, request acceptance and SRAM drive
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        init_done    = 1'b0;
        req_rdy      = 1'b0;
        xfer         = 1'b0;
        rd_xfer      = 1'b0;
        sram_CEN     = 1'b1;
        sram_GWEN    = 1'b1;
        sram_WEN     = '1;
        sram_A       = '0;
        sram_D       = '0;

        // Outputs are gated by RST so the reset values appear immediately,
        // not only after the first reset edge.
        if (!RST) begin
            case (state)
                ST_INIT: begin
                    sram_CEN     = 1'b0;
                    sram_GWEN    = 1'b0;
                    sram_WEN     = '0;
                    sram_A       = init_cnt;
                    sram_D       = '0;
                    init_cnt_nxt = init_cnt + ADDR_WIDTH'(1);
                    if (init_cnt == '1) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    // A/D pass through even when idle; they are don't-care
                    // while CEN is high and this keeps the drive mux small.
                    sram_A    = req_addr;
                    sram_D    = req_wdata;
                    // Reads need a free capture slot: nothing in flight and
                    // the response register empty or draining this edge.
                    req_rdy   = req_wr || (!rd_inflight && (!rsp_vld || rsp_rdy));
                    xfer      = req_vld && req_rdy;
                    rd_xfer   = xfer && !req_wr;
                    if (xfer) begin
                        sram_CEN = 1'b0;
                        if (req_wr) begin
                            sram_WEN  = ~req_wmask;
                            // An all-zero mask still performs an access but
                            // keeps the global write enable off.
                            sram_GWEN = ~(|req_wmask);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_f_spsram_acc_ctrl
//
// Directed bench for ct_f_spsram_acc_ctrl at default parameters
// (ADDR_WIDTH=8, DATA_WIDTH=54, INIT_EN=1). A behavioural single-port SRAM
// sits on the sram_* pins. Inputs change just after each falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_ct_f_spsram_acc_ctrl;

    localparam int AW = 8;
    localparam int DW = 54;

    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] VA   = 54'h2A_5555_AAAA_1234;
    localparam logic [DW-1:0] M27  = 54'h00_0000_07FF_FFFF;
    localparam logic [DW-1:0] NM27 = 54'h3F_FFFF_F800_0000;
    localparam logic [DW-1:0] VC   = 54'h15_1234_5678_9ABC;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_A;
    logic          sram_CEN;
    logic          sram_GWEN;
    logic [DW-1:0] sram_WEN;
    logic [DW-1:0] sram_D;
    logic [DW-1:0] sram_Q;

    ct_f_spsram_acc_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_EN    (1'b1)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_A    (sram_A),
        .sram_CEN  (sram_CEN),
        .sram_GWEN (sram_GWEN),
        .sram_WEN  (sram_WEN),
        .sram_D    (sram_D),
        .sram_Q    (sram_Q)
    );

    // ---------------- SRAM model ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (!sram_CEN) begin
            if (!sram_GWEN) begin
                mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
            end else begin
                sram_Q <= mem[sram_A];
            end
        end
    end

    // ---------------- counters and checkers ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {CEN, GWEN, WEN} only, for cycles where A/D are don't-care
    task automatic chk_ctl(input string tag, input logic cen, input logic gwen, input logic [DW-1:0] wen);
        n_assert++;
        assert ({sram_CEN, sram_GWEN, sram_WEN} === {cen, gwen, wen}) else begin
            n_fail++;
            $error("FAIL %s: observed CEN=%b GWEN=%b WEN=%h expected CEN=%b GWEN=%b WEN=%h",
                   tag, sram_CEN, sram_GWEN, sram_WEN, cen, gwen, wen);
        end
    endtask

    task automatic chk_sram(input string tag, input logic cen, input logic gwen,
                            input logic [DW-1:0] wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        n_assert++;
        assert ({sram_CEN, sram_GWEN, sram_WEN, sram_A, sram_D} === {cen, gwen, wen, a, d}) else begin
            n_fail++;
            $error("FAIL %s: observed CEN=%b GWEN=%b WEN=%h A=%h D=%h expected CEN=%b GWEN=%b WEN=%h A=%h D=%h",
                   tag, sram_CEN, sram_GWEN, sram_WEN, sram_A, sram_D, cen, gwen, wen, a, d);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_vld   = v;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_bit({tag, "_req_rdy"}, req_rdy, 1'b0);
        chk_bit({tag, "_rsp_vld"}, rsp_vld, 1'b0);
        chk_bit({tag, "_init_done"}, init_done, 1'b0);
        chk_sram({tag, "_sram"}, 1'b1, 1'b1, ONES, 8'h00, ZERO);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst     = 1'b1;
        rsp_rdy = 1'b1;
        drive(1'b0, 1'b0, 8'h00, ZERO, ZERO);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        chk_data("reset_rsp_rdata", rsp_rdata, ZERO);

        // Fill, interrupted at cycle 100. A pending write is presented the
        // whole time to show it is neither accepted nor issued.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'h77, ONES, ONES);
        for (int k = 0; k < 100; k++) begin
            #1;
            chk_sram("fill1_sram", 1'b0, 1'b0, ZERO, AW'(k), ZERO);
            chk_bit("fill1_req_rdy", req_rdy, 1'b0);
            chk_bit("fill1_init_done", init_done, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk_reset_outputs("midfill_reset");
        @(negedge clk);
        rst = 1'b0;

        // Full fill restarting at address 0
        for (int k = 0; k < 256; k++) begin
            #1;
            chk_sram("fill2_sram", 1'b0, 1'b0, ZERO, AW'(k), ZERO);
            chk_bit("fill2_req_rdy", req_rdy, 1'b0);
            chk_bit("fill2_init_done", init_done, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 8'h00, ZERO, ZERO);
        #1;
        chk_bit("run_init_done", init_done, 1'b1);
        chk_bit("run_req_rdy", req_rdy, 1'b1);
        chk_ctl("run_idle", 1'b1, 1'b1, ONES);

        // Full-mask write then read of 0x10
        @(negedge clk); drive(1'b1, 1'b1, 8'h10, VA, ONES); #1;
        chk_bit("wr10_rdy", req_rdy, 1'b1);
        chk_sram("wr10_sram", 1'b0, 1'b0, ZERO, 8'h10, VA);
        @(negedge clk); drive(1'b1, 1'b0, 8'h10, ZERO, ZERO); #1;
        chk_bit("rd10_rdy", req_rdy, 1'b1);
        chk_sram("rd10_sram", 1'b0, 1'b1, ONES, 8'h10, ZERO);
        @(negedge clk); drive(1'b0, 1'b0, 8'h00, ZERO, ZERO); #1;
        chk_bit("rd10_n1_rsp_vld", rsp_vld, 1'b0);
        chk_ctl("rd10_n1_idle", 1'b1, 1'b1, ONES);
        @(negedge clk); #1;
        chk_bit("rd10_n2_rsp_vld", rsp_vld, 1'b1);
        chk_data("rd10_n2_rdata", rsp_rdata, VA);
        @(negedge clk); #1;
        chk_bit("rd10_n3_rsp_vld", rsp_vld, 1'b0);

        // Partial write to 0x20, zero-mask write, read back
        @(negedge clk); drive(1'b1, 1'b1, 8'h20, ONES, M27); #1;
        chk_sram("wr20_part_sram", 1'b0, 1'b0, NM27, 8'h20, ONES);
        @(negedge clk); drive(1'b1, 1'b1, 8'h20, ZERO, ZERO); #1;
        chk_bit("wr20_m0_rdy", req_rdy, 1'b1);
        chk_sram("wr20_m0_sram", 1'b0, 1'b1, ONES, 8'h20, ZERO);
        @(negedge clk); drive(1'b1, 1'b0, 8'h20, ZERO, ZERO); #1;
        chk_bit("rd20_rdy", req_rdy, 1'b1);
        @(negedge clk); drive(1'b0, 1'b0, 8'h00, ZERO, ZERO);
        @(negedge clk); #1;
        chk_bit("rd20_rsp_vld", rsp_vld, 1'b1);
        chk_data("rd20_rdata", rsp_rdata, 54'h00_0000_07FF_FFFF);
        @(negedge clk); #1;
        chk_bit("rd20_done_rsp_vld", rsp_vld, 1'b0);

        // Read 0x05 with a stalled response
        @(negedge clk); drive(1'b1, 1'b1, 8'h05, VC, ONES); #1;
        chk_bit("wr05_rdy", req_rdy, 1'b1);
        @(negedge clk); drive(1'b1, 1'b0, 8'h05, ZERO, ZERO); rsp_rdy = 1'b0; #1;
        chk_bit("rd05_rdy", req_rdy, 1'b1);
        @(negedge clk); drive(1'b1, 1'b0, 8'h06, ZERO, ZERO); #1;
        chk_bit("rd05_n1_rdy", req_rdy, 1'b0);
        chk_bit("rd05_n1_rsp_vld", rsp_vld, 1'b0);
        chk_ctl("rd05_n1_idle", 1'b1, 1'b1, ONES);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 3) drive(1'b1, 1'b0, 8'h06, ZERO, ZERO);
            else       drive(1'b1, 1'b1, AW'(8'h40 + i - 3), DW'(i), ONES);
            #1;
            chk_bit("stall_rsp_vld", rsp_vld, 1'b1);
            chk_data("stall_rdata", rsp_rdata, VC);
            if (i < 3) begin
                chk_bit("stall_rd_rdy", req_rdy, 1'b0);
                chk_ctl("stall_rd_idle", 1'b1, 1'b1, ONES);
            end else begin
                chk_bit("stall_wr_rdy", req_rdy, 1'b1);
                chk_sram("stall_wr_sram", 1'b0, 1'b0, ZERO, AW'(8'h40 + i - 3), DW'(i));
            end
        end
        @(negedge clk); rsp_rdy = 1'b1; drive(1'b1, 1'b0, 8'h40, ZERO, ZERO); #1;
        chk_bit("drain_rsp_vld", rsp_vld, 1'b1);
        chk_data("drain_rdata", rsp_rdata, VC);
        chk_bit("rd40_rdy", req_rdy, 1'b1);
        chk_sram("rd40_sram", 1'b0, 1'b1, ONES, 8'h40, ZERO);
        @(negedge clk); drive(1'b0, 1'b0, 8'h00, ZERO, ZERO); #1;
        chk_bit("rd40_n1_rsp_vld", rsp_vld, 1'b0);
        @(negedge clk); #1;
        chk_bit("rd40_rsp_vld", rsp_vld, 1'b1);
        chk_data("rd40_rdata", rsp_rdata, 54'h3);

        // Back-to-back writes (one per cycle) then reads 0x01..0x03
        @(negedge clk); drive(1'b1, 1'b1, 8'h01, 54'h11, ONES); #1;
        chk_bit("wr01_rdy", req_rdy, 1'b1);
        @(negedge clk); drive(1'b1, 1'b1, 8'h02, 54'h22, ONES); #1;
        chk_bit("wr02_rdy", req_rdy, 1'b1);
        chk_sram("wr02_sram", 1'b0, 1'b0, ZERO, 8'h02, 54'h22);
        @(negedge clk); drive(1'b1, 1'b1, 8'h03, 54'h33, ONES); #1;
        chk_bit("wr03_rdy", req_rdy, 1'b1);
        @(negedge clk); drive(1'b1, 1'b0, 8'h01, ZERO, ZERO); #1;
        chk_bit("b2b_n0_rdy", req_rdy, 1'b1);
        chk_bit("b2b_n0_rsp_vld", rsp_vld, 1'b0);
        @(negedge clk); drive(1'b1, 1'b0, 8'h02, ZERO, ZERO); #1;
        chk_bit("b2b_n1_rdy", req_rdy, 1'b0);
        chk_bit("b2b_n1_rsp_vld", rsp_vld, 1'b0);
        @(negedge clk); #1;
        chk_bit("b2b_n2_rdy", req_rdy, 1'b1);
        chk_bit("b2b_n2_rsp_vld", rsp_vld, 1'b1);
        chk_data("b2b_n2_rdata", rsp_rdata, 54'h11);
        @(negedge clk); drive(1'b1, 1'b0, 8'h03, ZERO, ZERO); #1;
        chk_bit("b2b_n3_rdy", req_rdy, 1'b0);
        chk_bit("b2b_n3_rsp_vld", rsp_vld, 1'b0);
        @(negedge clk); #1;
        chk_bit("b2b_n4_rdy", req_rdy, 1'b1);
        chk_bit("b2b_n4_rsp_vld", rsp_vld, 1'b1);
        chk_data("b2b_n4_rdata", rsp_rdata, 54'h22);
        @(negedge clk); drive(1'b0, 1'b0, 8'h00, ZERO, ZERO); #1;
        chk_bit("b2b_n5_rsp_vld", rsp_vld, 1'b0);
        @(negedge clk); #1;
        chk_bit("b2b_n6_rsp_vld", rsp_vld, 1'b1);
        chk_data("b2b_n6_rdata", rsp_rdata, 54'h33);

        // Read 0x30 followed by a same-address write in the in-flight cycle
        @(negedge clk); drive(1'b1, 1'b1, 8'h30, 54'h2A, ONES); #1;
        chk_bit("wr30_old_rdy", req_rdy, 1'b1);
        @(negedge clk); drive(1'b1, 1'b0, 8'h30, ZERO, ZERO); #1;
        chk_bit("rd30_rdy", req_rdy, 1'b1);
        @(negedge clk); drive(1'b1, 1'b1, 8'h30, 54'h1, ONES); #1;
        chk_bit("wr30_new_rdy", req_rdy, 1'b1);
        chk_sram("wr30_new_sram", 1'b0, 1'b0, ZERO, 8'h30, 54'h1);
        @(negedge clk); drive(1'b0, 1'b0, 8'h00, ZERO, ZERO); #1;
        chk_bit("rd30_rsp_vld", rsp_vld, 1'b1);
        chk_data("rd30_old_rdata", rsp_rdata, 54'h2A);
        @(negedge clk); drive(1'b1, 1'b0, 8'h30, ZERO, ZERO); #1;
        chk_bit("rd30b_rdy", req_rdy, 1'b1);
        @(negedge clk); drive(1'b0, 1'b0, 8'h00, ZERO, ZERO); #1;
        chk_bit("rd30b_n1_rsp_vld", rsp_vld, 1'b0);
        @(negedge clk); #1;
        chk_bit("rd30b_rsp_vld", rsp_vld, 1'b1);
        chk_data("rd30b_new_rdata", rsp_rdata, 54'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
